// File: rtl/cdc_pkg.sv
// cdc_pkg: handshake sender state encoding and synchronizer depth floor.
package cdc_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cdc_state_e;
    localparam int SYNC_DEPTH_MIN = 2;
endpackage

// File: rtl/sys_structs.sv
// sys_structs: shared clock-domain bundle carrying clock, synchronous reset and advance enable.
package sys_structs;
    typedef struct packed {
        logic clk;
        logic sync_rst;
        logic clk_en;
    } clk_dom_sain;
endpackage

// File: rtl/cdc_handshake_sender_if.sv
// cdc_handshake_sender_if: valid/ready source port plus req/ack crossing bus.
// The timeout flag exists only when CDC_HANDSHAKE_SENDER_TIMEOUT_EN is defined.
interface cdc_handshake_sender_if #(parameter int DATA_WIDTH = 32);
    logic                  send_valid;
    logic [DATA_WIDTH-1:0] send_data;
    logic                  send_ready;
    logic                  xfer_req;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  xfer_ack;
    logic                  done;
    logic                  busy;
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    logic                  timeout;
`endif
    modport slave (
        input  send_valid, send_data, xfer_ack,
        output send_ready, xfer_req, xfer_data, done, busy
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        , output timeout
`endif
    );
    modport master (
        output send_valid, send_data, xfer_ack,
        input  send_ready, xfer_req, xfer_data, done, busy
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/synchronization_chain.sv
// synchronization_chain: CHAIN_DEPTH-stage flop chain for asynchronous inputs; deliberately unreset.
module synchronization_chain #(
    parameter int CHAIN_DEPTH = 2,
    parameter int CHAIN_WIDTH = 1
) (
    input  logic                   clk,
    input  logic [CHAIN_WIDTH-1:0] d_i,
    output logic [CHAIN_WIDTH-1:0] q_o
);
    logic [CHAIN_WIDTH-1:0] stage_q [CHAIN_DEPTH];
    always_ff @(posedge clk) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < CHAIN_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
    assign q_o = stage_q[CHAIN_DEPTH-1];
endmodule

// File: rtl/cdc_handshake_sender.sv
// cdc_handshake_sender: source end of a four-phase req/ack CDC handshake.
// Define CDC_HANDSHAKE_SENDER_TIMEOUT_EN to add the sticky wait-state timeout flag.
module cdc_handshake_sender
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input sys_structs::clk_dom_sain clk_dom_i,
    cdc_handshake_sender_if.slave   bus
);
    if (SYNC_DEPTH < SYNC_DEPTH_MIN || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_handshake_sender: SYNC_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic clk, rst, en, ack_sync, accept;
    assign clk = clk_dom_i.clk;
    assign rst = clk_dom_i.sync_rst;
    assign en  = clk_dom_i.clk_en;

    synchronization_chain #(.CHAIN_DEPTH(SYNC_DEPTH), .CHAIN_WIDTH(1)) u_ack_sync (
        .clk (clk),
        .d_i (bus.xfer_ack),
        .q_o (ack_sync)
    );

    cdc_state_e            state_q, state_d;
    logic                  req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A stale ack left over from before reset keeps ready low until the destination drops it.
    assign bus.send_ready = state_q == IDLE && !ack_sync;
    assign accept         = bus.send_valid && bus.send_ready;

    always_comb begin
        state_d = !en ? state_q :
                  accept ? REQ :
                  (state_q == REQ && ack_sync) ? RELEASE :
                  (state_q == RELEASE && !ack_sync) ? IDLE : state_q;
        data_d  = (en && accept) ? bus.send_data : data_q;
        done_d  = !en ? done_q : state_q == RELEASE && !ack_sync;
        req_d   = state_d == REQ;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.xfer_req  = req_q;
    assign bus.xfer_data = data_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Saturating wait counter; the FSM never aborts, the flag only reports.
    always_comb begin
        cnt_d     = !en ? cnt_q :
                    state_d != state_q ? '0 :
                    (busy_q && cnt_q != CW'(TIMEOUT_CYCLES)) ? cnt_q + CW'(1) : cnt_q;
        timeout_d = timeout_q || cnt_d == CW'(TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`endif
endmodule

// File: tb/tb_cdc_handshake_sender.sv
// tb_cdc_handshake_sender: scoreboard bench for the handshake sender, loopback and manual ack modes.
module tb_cdc_handshake_sender;
    import sys_structs::*;
    localparam int DW = 32;
    localparam int SD = 2;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic rst, clk_en, loop, ack_man;
    clk_dom_sain dom;
    always #5 clk = ~clk;
    assign dom.clk      = clk;
    assign dom.sync_rst = rst;
    assign dom.clk_en   = clk_en;

    cdc_handshake_sender_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.xfer_ack = loop ? bus.xfer_req : ack_man;

    cdc_handshake_sender #(.DATA_WIDTH(DW), .SYNC_DEPTH(SD), .TIMEOUT_CYCLES(TO)) dut (
        .clk_dom_i (dom),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    exp_t sb[$];
    exp_t e;
    logic [DW-1:0] held;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; loop = 1'b0; ack_man = 1'b0;
        bus.send_valid = 1'b0; bus.send_data = '0;
        cyc = 0;
        repeat (4) step();
        n_cmp++;
        if ({bus.xfer_req, bus.done, bus.busy, bus.send_ready} !== 4'b0001) begin
            n_bad++; $display("FAIL reset_ctrl: req/done/busy/ready=%b required 0001", {bus.xfer_req, bus.done, bus.busy, bus.send_ready});
        end
        n_cmp++;
        if (bus.xfer_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h required 0", bus.xfer_data); end
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        n_cmp++;
        if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b required 0", bus.timeout); end
`endif
        rst = 1'b0;
        held = '0;
        step();
    endtask

    task automatic test_loopback();
        logic [3:0] got, want;
        loop = 1'b1; cyc = 0;
        bus.send_valid = 1'b1; bus.send_data = 32'hDEADBEEF;
        n_cmp++;
        if (bus.send_ready !== 1'b1) begin n_bad++; $display("FAIL lb_ready0: got %b required 1", bus.send_ready); end
        sb.push_back('{32'hDEADBEEF, 7});
        step();
        held = 32'hDEADBEEF;
        bus.send_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus.send_data = $urandom;
            got  = {bus.xfer_req, bus.busy, bus.send_ready, bus.done};
            want = {c <= 3, c <= 6, c >= 7, c == 7};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL lb_timing: cycle %0d req/busy/ready/done=%b required %b", c, got, want); end
            n_cmp++;
            if (bus.xfer_data !== held) begin n_bad++; $display("FAIL lb_data: cycle %0d got %h required %h", c, bus.xfer_data, held); end
            if (bus.done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL lb_done: unexpected done at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (bus.xfer_data !== e.d || cyc != e.c) begin
                        n_bad++; $display("FAIL lb_done: got %h at cycle %0d required %h at cycle %0d", bus.xfer_data, cyc, e.d, e.c);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL lb_missing: %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [3];
        int idx;
        logic acc;
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
        loop = 1'b1; cyc = 0; idx = 0;
        bus.send_valid = 1'b1; bus.send_data = words[0];
        for (int k = 0; k < 30; k++) begin
            n_cmp++;
            if (bus.xfer_data !== held) begin n_bad++; $display("FAIL b2b_data: cycle %0d got %h required %h", cyc, bus.xfer_data, held); end
            if (bus.done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_done: unexpected done at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (bus.xfer_data !== e.d || cyc != e.c) begin
                        n_bad++; $display("FAIL b2b_done: got %h at cycle %0d required %h at cycle %0d", bus.xfer_data, cyc, e.d, e.c);
                    end
                end
            end
            acc = bus.send_valid && bus.send_ready;
            if (acc) begin
                n_cmp++;
                if (cyc != idx * 7) begin n_bad++; $display("FAIL b2b_accept: word %0d at cycle %0d required %0d", idx, cyc, idx * 7); end
                sb.push_back('{words[idx], cyc + 7});
            end
            step();
            if (acc) begin
                held = words[idx];
                idx++;
                bus.send_valid = idx < 3;
                bus.send_data = idx < 3 ? words[idx] : '0;
            end
        end
        bus.send_valid = 1'b0;
        n_cmp++;
        if (idx != 3 || sb.size() != 0) begin n_bad++; $display("FAIL b2b_count: accepted %0d pending %0d required 3 and 0", idx, sb.size()); sb.delete(); end
    endtask

    task automatic test_delayed();
        int req_fall;
        loop = 1'b0; ack_man = 1'b0; cyc = 0; req_fall = -1;
        bus.send_valid = 1'b1; bus.send_data = 32'hA5A50F0F;
        n_cmp++;
        if (bus.send_ready !== 1'b1) begin n_bad++; $display("FAIL dly_ready0: got %b required 1", bus.send_ready); end
        sb.push_back('{32'hA5A50F0F, 42});
        step();
        held = 32'hA5A50F0F;
        bus.send_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 21) ack_man = 1'b1;
            if (k == 39) ack_man = 1'b0;
            if (req_fall < 0 && !bus.xfer_req) req_fall = k;
            if (bus.done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL dly_done: unexpected done at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (bus.xfer_data !== e.d || cyc != e.c) begin
                        n_bad++; $display("FAIL dly_done: got %h at cycle %0d required %h at cycle %0d", bus.xfer_data, cyc, e.d, e.c);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (req_fall != 22 + SD) begin n_bad++; $display("FAIL dly_req_fall: cycle %0d required %0d", req_fall, 22 + SD); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL dly_missing: %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_stuck_ack();
        loop = 1'b0; ack_man = 1'b0; cyc = 0;
        bus.send_valid = 1'b1; bus.send_data = 32'h11112222;
        step();
        bus.send_valid = 1'b0; ack_man = 1'b1;
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({bus.xfer_req, bus.busy, bus.send_ready} !== 3'b000) begin
            n_bad++; $display("FAIL rst_req: req/busy/ready=%b required 000", {bus.xfer_req, bus.busy, bus.send_ready});
        end
        step();
        rst = 1'b0; held = '0;
        bus.send_valid = 1'b1; bus.send_data = 32'h55AA55AA;
        for (int k = 4; k <= 20; k++) begin
            if (k == 10) ack_man = 1'b0;
            if (k <= 12) begin
                n_cmp++;
                if (bus.send_ready !== (k >= 12) || bus.busy !== 1'b0) begin
                    n_bad++; $display("FAIL rst_ready: cycle %0d ready/busy=%b%b required %b0", k, bus.send_ready, bus.busy, k >= 12);
                end
            end
            n_cmp++;
            if (bus.xfer_data !== held) begin n_bad++; $display("FAIL rst_data: cycle %0d got %h required %h", k, bus.xfer_data, held); end
            if (bus.done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rst_done: unexpected done at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (bus.xfer_data !== e.d || cyc != e.c) begin
                        n_bad++; $display("FAIL rst_done: got %h at cycle %0d required %h at cycle %0d", bus.xfer_data, cyc, e.d, e.c);
                    end
                end
            end
            if (bus.send_valid && bus.send_ready) begin
                sb.push_back('{32'h55AA55AA, cyc + 7});
                loop = 1'b1;
                step();
                held = 32'h55AA55AA;
                bus.send_valid = 1'b0;
            end else step();
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL rst_missing: %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clk_en();
        loop = 1'b1; cyc = 0;
        bus.send_valid = 1'b1; bus.send_data = 32'hC0FFEE00;
        n_cmp++;
        if (bus.send_ready !== 1'b1) begin n_bad++; $display("FAIL en_ready0: got %b required 1", bus.send_ready); end
        sb.push_back('{32'hC0FFEE00, 12});
        step();
        held = 32'hC0FFEE00;
        bus.send_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            clk_en = !(k >= 6 && k <= 10);
            n_cmp++;
            if (bus.xfer_data !== held) begin n_bad++; $display("FAIL en_data: cycle %0d got %h required %h", k, bus.xfer_data, held); end
            if (bus.done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL en_done: unexpected done at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (bus.xfer_data !== e.d || cyc != e.c) begin
                        n_bad++; $display("FAIL en_done: got %h at cycle %0d required %h at cycle %0d", bus.xfer_data, cyc, e.d, e.c);
                    end
                end
            end
            step();
        end
        clk_en = 1'b1;
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL en_missing: %0d pending required 0", sb.size()); sb.delete(); end
    endtask

`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    task automatic test_timeout();
        loop = 1'b0; ack_man = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        cyc = 0;
        bus.send_valid = 1'b1; bus.send_data = 32'h0BADF00D;
        step();
        bus.send_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            n_cmp++;
            if (bus.timeout !== (k >= TO + 1) || bus.xfer_req !== 1'b1) begin
                n_bad++; $display("FAIL to_flag: cycle %0d timeout/req=%b%b required %b1", k, bus.timeout, bus.xfer_req, k >= TO + 1);
            end
            step();
        end
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_delayed();
        test_reset_stuck_ack();
        test_clk_en();
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
